// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared definitions for the image streaming processor: point-operation mode
// codes, the frame FSM state encoding, the output FIFO depth and the unsigned
// 8-bit saturation helper used by the brightness operations.
// ---------------------------------------------------------------------------
package img_pkg;

  localparam logic [2:0] MODE_PASS       = 3'd0;
  localparam logic [2:0] MODE_BRIGHT_ADD = 3'd1;
  localparam logic [2:0] MODE_BRIGHT_SUB = 3'd2;
  localparam logic [2:0] MODE_INVERT     = 3'd3;
  localparam logic [2:0] MODE_GRAY       = 3'd4;
  localparam logic [2:0] MODE_THRESH     = 3'd5;

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VSYNC = 3'd1,
    ST_HSYNC = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Clamp a signed 10-bit intermediate (range -255..510) into 0..255.
  function automatic logic [7:0] sat_u8(input logic signed [9:0] x);
    if (x < 0)
      return 8'd0;
    else if (x > 10'sd255)
      return 8'hFF;
    else
      return x[7:0];
  endfunction

endpackage

// File: rtl/pix_op_unit.sv
// ---------------------------------------------------------------------------
// pix_op_unit
// Purely combinational point operation on a single RGB888 pixel.
// Ports:
//   i_mode  [2:0]  operation select (MODE_* codes, reserved codes pass through)
//   i_value [7:0]  brightness offset or threshold
//   i_rgb   [23:0] input pixel, R in [7:0], G in [15:8], B in [23:16]
//   o_rgb   [23:0] processed pixel, same packing
// ---------------------------------------------------------------------------
module pix_op_unit
  import img_pkg::*;
(
  input  logic [2:0]  i_mode,
  input  logic [7:0]  i_value,
  input  logic [23:0] i_rgb,
  output logic [23:0] o_rgb
);

  logic [9:0] w_sum;
  logic [7:0] w_gray;

  // Gray level is the truncated mean of the three channels; the 10-bit sum
  // holds the worst case 3*255 = 765 without overflow.
  assign w_sum  = 10'(i_rgb[7:0]) + 10'(i_rgb[15:8]) + 10'(i_rgb[23:16]);
  assign w_gray = 8'(w_sum / 10'd3);

  // Select the operation; brightness math is done in signed 10-bit so both
  // the overflow and the underflow side can be clamped by sat_u8.
  always_comb begin
    o_rgb = i_rgb;
    case (i_mode)
      MODE_BRIGHT_ADD: begin
        for (int k = 0; k < 3; k++)
          o_rgb[8*k +: 8] = sat_u8(signed'({2'b00, i_rgb[8*k +: 8]}) + signed'({2'b00, i_value}));
      end
      MODE_BRIGHT_SUB: begin
        for (int k = 0; k < 3; k++)
          o_rgb[8*k +: 8] = sat_u8(signed'({2'b00, i_rgb[8*k +: 8]}) - signed'({2'b00, i_value}));
      end
      MODE_INVERT: o_rgb = ~i_rgb;
      MODE_GRAY:   o_rgb = {3{w_gray}};
      MODE_THRESH: o_rgb = (w_gray > i_value) ? 24'hFFFFFF : 24'h000000;
      default:     o_rgb = i_rgb;
    endcase
  end

endmodule

// File: rtl/image_stream_proc.sv
// ---------------------------------------------------------------------------
// image_stream_proc
// Reads one frame from an external pixel memory, PIX_PER_CLK pixels per word,
// applies a point operation chosen at start time and streams the result out
// over valid/ready with sof/eol/eof markers and VSYNC/HSYNC phase flags.
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   start, mode, value  frame start pulse plus op select/parameter (latched)
//   mem_rd_en, mem_addr memory read strobe and word address
//   mem_rdata           read data, valid one cycle after mem_rd_en
//   out_valid/ready     output stream handshake
//   out_data            processed pixels, same packing as mem_rdata
//   out_sof/eol/eof     first-of-frame / last-of-line / last-of-frame markers
//   VSYNC, HSYNC        high in the VSYNC and DATA phases respectively
//   busy, frame_done    frame in progress / pulse after eof is accepted
// ---------------------------------------------------------------------------
module image_stream_proc
  import img_pkg::*;
#(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int PIX_PER_CLK    = 2,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int BOTTOM_UP      = 1,
  parameter int ADDR_W         = 18
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      start,
  input  logic [2:0]                mode,
  input  logic [7:0]                value,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [PIX_PER_CLK*24-1:0] mem_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PIX_PER_CLK*24-1:0] out_data,
  output logic                      out_sof,
  output logic                      out_eol,
  output logic                      out_eof,
  output logic                      VSYNC,
  output logic                      HSYNC,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int COLS  = WIDTH / PIX_PER_CLK;
  localparam int DW    = PIX_PER_CLK * 24;
  localparam int COL_W = $clog2(COLS + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);
  localparam int DLY_W = 16;

  state_t             r_state;
  logic [DLY_W-1:0]   r_dly;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [2:0]         r_mode;
  logic [7:0]         r_value;
  logic               r_frameDone;

  logic               r_pendValid;
  logic [2:0]         r_pendMark;
  logic               r_capValid;
  logic [2:0]         r_capMark;
  logic [DW-1:0]      r_capData;

  logic [DW+2:0]      r_fifo [FIFO_DEPTH];
  logic [1:0]         r_wrPtr;
  logic [1:0]         r_rdPtr;
  logic [2:0]         r_fifoCount;

  logic               w_issue;
  logic               w_lastCol;
  logic               w_lastRow;
  logic [2:0]         w_inflight;
  logic [2:0]         w_mark;
  logic [ADDR_W-1:0]  w_mline;
  logic [ADDR_W-1:0]  w_addr;
  logic [DW-1:0]      w_opData;
  logic [DW+2:0]      w_head;
  logic               w_valid;
  logic               w_push;
  logic               w_pop;
  logic               w_eofAccept;
  logic               w_startOk;

  // A read may only be issued when every word already in the pipeline plus
  // the new one fits in the FIFO, so no out_ready pattern can overflow it.
  assign w_inflight = 3'(r_pendValid) + 3'(r_capValid);
  assign w_issue    = (r_state == ST_DATA) && ((r_fifoCount + w_inflight) < 3'(FIFO_DEPTH));
  assign w_lastCol  = (r_col == COL_W'(COLS - 1));
  assign w_lastRow  = (r_row == ROW_W'(HEIGHT - 1));

  // Markers are decided at issue time and ride along with the word.
  assign w_mark = {w_lastCol && w_lastRow, w_lastCol, (r_row == '0) && (r_col == '0)};

  // Bottom-up order reads the last memory line first, matching BMP layout.
  assign w_mline   = (BOTTOM_UP != 0) ? (ADDR_W'(HEIGHT - 1) - ADDR_W'(r_row)) : ADDR_W'(r_row);
  assign w_addr    = w_mline * ADDR_W'(COLS) + ADDR_W'(r_col);
  assign mem_rd_en = w_issue;
  assign mem_addr  = w_issue ? w_addr : '0;

  assign w_head      = r_fifo[r_rdPtr];
  assign w_valid     = (r_fifoCount != 3'd0);
  assign w_push      = r_capValid;
  assign w_pop       = w_valid && out_ready;
  assign w_eofAccept = w_pop && w_head[DW+2];
  // The cycle frame_done is high the FSM is already idle; a start there is
  // deliberately refused so a frame is only started from a settled idle.
  assign w_startOk   = start && (r_state == ST_IDLE) && !r_frameDone;

  // Frame sequencer: phase timing, line/column position, op latching and
  // the done pulse all live in this one block.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_dly       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_mode      <= MODE_PASS;
      r_value     <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_eofAccept;
      case (r_state)
        ST_IDLE: begin
          if (w_startOk) begin
            r_state <= ST_VSYNC;
            r_dly   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_mode  <= mode;
            r_value <= value;
          end
        end
        ST_VSYNC: begin
          if (r_dly == DLY_W'(START_UP_DELAY - 1)) begin
            r_state <= ST_HSYNC;
            r_dly   <= '0;
          end else begin
            r_dly <= r_dly + 1'b1;
          end
        end
        ST_HSYNC: begin
          if (r_dly == DLY_W'(HSYNC_DELAY - 1)) begin
            r_state <= ST_DATA;
            r_dly   <= '0;
            r_col   <= '0;
          end else begin
            r_dly <= r_dly + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_issue) begin
            if (w_lastCol) begin
              r_col <= '0;
              if (w_lastRow) begin
                r_state <= ST_DRAIN;
              end else begin
                r_row   <= r_row + 1'b1;
                r_state <= ST_HSYNC;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_eofAccept)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read pipeline: the pending stage marks the cycle mem_rdata is valid,
  // the capture stage holds the word that the op units work on.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pendValid <= 1'b0;
      r_pendMark  <= '0;
      r_capValid  <= 1'b0;
      r_capMark   <= '0;
      r_capData   <= '0;
    end else begin
      r_pendValid <= w_issue;
      r_pendMark  <= w_mark;
      r_capValid  <= r_pendValid;
      r_capMark   <= r_pendMark;
      if (r_pendValid)
        r_capData <= mem_rdata;
    end
  end

  for (genvar p = 0; p < PIX_PER_CLK; p++) begin : g_op
    pix_op_unit u_op (
      .i_mode  (r_mode),
      .i_value (r_value),
      .i_rgb   (r_capData[24*p +: 24]),
      .o_rgb   (w_opData[24*p +: 24])
    );
  end

  // FIFO bookkeeping; the op result is registered straight into the FIFO,
  // which keeps the read-to-valid latency at three cycles.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_fifoCount <= '0;
    end else begin
      if (w_push)
        r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)
        r_rdPtr <= r_rdPtr + 1'b1;
      r_fifoCount <= r_fifoCount + 3'(w_push) - 3'(w_pop);
    end
  end

  // FIFO storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge HCLK) begin
    if (!HRESET && w_push)
      r_fifo[r_wrPtr] <= {r_capMark, w_opData};
  end

  assign out_valid  = w_valid;
  assign out_data   = w_valid ? w_head[DW-1:0] : '0;
  assign out_sof    = w_valid && w_head[DW];
  assign out_eol    = w_valid && w_head[DW+1];
  assign out_eof    = w_valid && w_head[DW+2];
  assign VSYNC      = (r_state == ST_VSYNC);
  assign HSYNC      = (r_state == ST_DATA);
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_image_stream_proc.sv
// ---------------------------------------------------------------------------
// tb_image_stream_proc
// Self-checking bench for image_stream_proc on a small 8x2 frame, two pixels
// per beat. Expected beats and read addresses are queued when a frame is
// started and compared as the design produces them.
// ---------------------------------------------------------------------------
module tb_image_stream_proc;
  import img_pkg::*;

  localparam int W    = 8;
  localparam int H    = 2;
  localparam int PPC  = 2;
  localparam int SUD  = 5;
  localparam int HD   = 3;
  localparam int AW   = 4;
  localparam int COLS = W / PPC;
  localparam int DW   = PPC * 24;

  logic           HCLK = 1'b0;
  logic           HRESET;
  logic           start;
  logic [2:0]     mode;
  logic [7:0]     value;
  logic           mem_rd_en;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_rdata = '0;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           out_sof, out_eol, out_eof;
  logic           VSYNC, HSYNC, busy, frame_done;

  image_stream_proc #(
    .WIDTH(W), .HEIGHT(H), .PIX_PER_CLK(PPC), .START_UP_DELAY(SUD),
    .HSYNC_DELAY(HD), .BOTTOM_UP(1), .ADDR_W(AW)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode), .value(value),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .busy(busy), .frame_done(frame_done)
  );

  always #5 HCLK = ~HCLK;

  // Pixel memory model with one cycle read latency.
  logic [DW-1:0] memArr [16];
  always @(posedge HCLK) if (mem_rd_en) mem_rdata <= memArr[mem_addr];

  int checks = 0;
  int errors = 0;
  logic [DW+2:0] expQ[$];
  logic [AW-1:0] addrQ[$];
  logic [DW-1:0] recv[$];

  int  cycleCnt = 0;
  int  eofCnt = 0, doneCnt = 0;
  int  outstanding = 0, maxOut = 0;
  int  vsCnt = 0, lastVs = 0, gapCnt = 0, lastGap = 0, hsCnt = 0;
  bit  measuring = 0, held = 0, randReady = 0;
  logic [DW+3:0] heldBeat;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] modelPix(input logic [2:0] m, input logic [7:0] v, input logic [23:0] p);
    int c[3];
    int g, r, vi;
    logic [23:0] o;
    vi = int'(v);
    for (int k = 0; k < 3; k++) c[k] = int'(p[8*k +: 8]);
    g = (c[0] + c[1] + c[2]) / 3;
    for (int k = 0; k < 3; k++) begin
      case (m)
        3'd1:    r = (c[k] + vi > 255) ? 255 : c[k] + vi;
        3'd2:    r = (c[k] - vi < 0) ? 0 : c[k] - vi;
        3'd3:    r = 255 - c[k];
        3'd4:    r = g;
        3'd5:    r = (g > vi) ? 255 : 0;
        default: r = c[k];
      endcase
      o[8*k +: 8] = 8'(r);
    end
    return o;
  endfunction

  always @(posedge HCLK) cycleCnt <= cycleCnt + 1;

  // Random or constant downstream ready, changed just after each edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge HCLK);
      #1;
      out_ready = randReady ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Output/address monitor sampled on the falling edge.
  always @(negedge HCLK) begin
    if (HRESET) begin
      outstanding = 0;
      held = 0;
      vsCnt = 0;
      measuring = 0;
    end else begin
      if (mem_rd_en) begin
        if (addrQ.size() == 0) checkOutput("extraRead", 1, 0);
        else checkOutput("readAddr", 64'(mem_addr), 64'(addrQ.pop_front()));
        outstanding++;
      end
      if (held) checkOutput("holdBeat", 64'({out_valid, out_eof, out_eol, out_sof, out_data}), 64'(heldBeat));
      held = out_valid && !out_ready;
      heldBeat = {out_valid, out_eof, out_eol, out_sof, out_data};
      if (out_valid && out_ready) begin
        outstanding--;
        if (expQ.size() == 0) checkOutput("extraBeat", 1, 0);
        else checkOutput("beat", 64'({out_eof, out_eol, out_sof, out_data}), 64'(expQ.pop_front()));
        recv.push_back(out_data);
        if (out_eof) eofCnt = cycleCnt;
      end
      if (outstanding > maxOut) maxOut = outstanding;
      if (frame_done) begin
        doneCnt++;
        checkOutput("doneLatency", 64'(cycleCnt - eofCnt), 1);
      end
      if (HSYNC) hsCnt++;
      if (VSYNC) vsCnt++;
      else begin
        if (vsCnt != 0) begin
          lastVs = vsCnt;
          vsCnt = 0;
          gapCnt = 0;
          measuring = 1;
        end
        if (measuring) begin
          if (mem_rd_en) begin
            lastGap = gapCnt;
            measuring = 0;
          end else gapCnt++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] m, input logic [7:0] v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < COLS; c++) begin
        int ml;
        logic [DW-1:0] d, word;
        logic sof, eol, eof;
        ml = H - 1 - r;
        word = memArr[ml*COLS + c];
        for (int p = 0; p < PPC; p++) d[24*p +: 24] = modelPix(m, v, word[24*p +: 24]);
        sof = (r == 0) && (c == 0);
        eol = (c == COLS - 1);
        eof = eol && (r == H - 1);
        expQ.push_back({eof, eol, sof, d});
        addrQ.push_back(AW'(ml*COLS + c));
      end
    @(posedge HCLK); #1;
    start = 1'b1; mode = m; value = v;
    @(posedge HCLK); #1;
    start = 1'b0; mode = 3'($urandom); value = 8'($urandom);
  endtask

  task automatic waitDone(input bit startAtDone);
    int n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!frame_done && n < 2000);
    if (!frame_done) checkOutput("doneTimeout", 0, 1);
    else begin
      checkOutput("busyAtDone", 64'(busy), 0);
      if (startAtDone) begin
        start = 1'b1; mode = MODE_INVERT;
        @(posedge HCLK); #1;
        start = 1'b0;
        @(negedge HCLK);
        checkOutput("startAtDoneIgnored", 64'({busy, VSYNC}), 0);
      end
    end
  endtask

  task automatic runFrame(input logic [2:0] m, input logic [7:0] v, input bit rnd, input bit midStart, input bit startAtDone);
    recv.delete();
    randReady = rnd; lastVs = 0; lastGap = -1; hsCnt = 0; maxOut = 0;
    applyStimulus(m, v);
    @(negedge HCLK) checkOutput("busyAfterStart", 64'(busy), 1);
    if (midStart) begin
      repeat (8) @(posedge HCLK);
      #1; start = 1'b1; mode = MODE_INVERT; value = 8'd200;
      @(posedge HCLK); #1; start = 1'b0;
    end
    waitDone(startAtDone);
    randReady = 0;
    repeat (4) @(negedge HCLK);
    checkOutput("expLeft", 64'(expQ.size()), 0);
    checkOutput("addrLeft", 64'(addrQ.size()), 0);
    checkOutput("beatCount", 64'(recv.size()), 8);
    checkOutput("vsyncLen", 64'(lastVs), SUD);
    checkOutput("hsyncGap", 64'(lastGap), HD);
    checkOutput("maxOutstanding", 64'(maxOut <= 4), 1);
    if (!rnd) checkOutput("dataCycles", 64'(hsCnt), 8);
  endtask

  initial begin
    int n, doneBefore;
    HRESET = 1'b1; start = 1'b0; mode = '0; value = '0;
    for (int i = 0; i < 16; i++) memArr[i] = {16'($urandom), $urandom};
    memArr[4] = {8'd91, 8'd60, 8'd30, 8'd50, 8'd100, 8'd200};
    memArr[5] = {24'h4B4B4B, 24'h505050};
    memArr[6] = {24'hFF0064, 24'hFF8000};
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    checkOutput("rstOutValid", 64'(out_valid), 0);
    checkOutput("rstFlags", 64'({busy, VSYNC, HSYNC, mem_rd_en, frame_done}), 0);
    checkOutput("rstData", 64'(out_data), 0);
    @(posedge HCLK); #1; HRESET = 1'b0;

    $display("[TB] pass-through frame");
    runFrame(MODE_PASS, 8'd0, 0, 0, 0);
    runFrame(MODE_BRIGHT_ADD, 8'd75, 0, 0, 0);
    if (recv.size() > 0) begin
      checkOutput("addSatR", 64'(recv[0][7:0]), 255);
      checkOutput("addG", 64'(recv[0][15:8]), 175);
    end
    runFrame(MODE_BRIGHT_SUB, 8'd75, 0, 1, 0);
    if (recv.size() > 0) begin
      checkOutput("subSatB", 64'(recv[0][23:16]), 0);
      checkOutput("subG", 64'(recv[0][15:8]), 25);
    end
    runFrame(MODE_GRAY, 8'd0, 0, 0, 0);
    if (recv.size() > 0) checkOutput("gray", 64'(recv[0][47:24]), 64'h3C3C3C);
    runFrame(MODE_THRESH, 8'd75, 0, 0, 0);
    if (recv.size() > 1) checkOutput("thresh", 64'(recv[1]), 64'h000000FFFFFF);
    runFrame(MODE_INVERT, 8'd0, 0, 0, 0);
    if (recv.size() > 2) checkOutput("invert", 64'(recv[2][23:0]), 64'h007FFF);

    $display("[TB] random ready frames");
    runFrame(MODE_PASS, 8'd0, 1, 0, 1);
    runFrame(MODE_GRAY, 8'd0, 1, 1, 0);
    runFrame(3'd7, 8'd33, 0, 0, 0);

    $display("[TB] reset mid-frame");
    recv.delete();
    applyStimulus(MODE_PASS, 8'd0);
    n = 0;
    while (recv.size() < 2 && n < 500) begin @(posedge HCLK); n++; end
    checkOutput("abortReached", 64'(recv.size() >= 2), 1);
    doneBefore = doneCnt;
    #1; HRESET = 1'b1;
    @(posedge HCLK); #1; HRESET = 1'b0;
    checkOutput("abortOutValid", 64'(out_valid), 0);
    checkOutput("abortFlags", 64'({busy, VSYNC, HSYNC}), 0);
    expQ.delete(); addrQ.delete();
    repeat (20) @(negedge HCLK);
    checkOutput("abortNoDone", 64'(doneCnt - doneBefore), 0);
    checkOutput("abortQuiet", 64'({out_valid, mem_rd_en, busy}), 0);
    runFrame(MODE_THRESH, 8'd75, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
